// File: rtl/pipe_decode.sv
// Single-stage instruction decoder with a registered, valid/ready output stage.
// Inserts a bubble on load-use hazards and can squash the instruction after a jump.
module pipe_decode #(
  parameter int IW            = 16,
  parameter int RW            = 3,
  parameter int IMMW          = 8,
  parameter int JW            = 5,
  parameter int CW            = 16,
  parameter int FLUSH_ON_JUMP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   instruction,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [4:0]      Op,
  output logic [1:0]      alusrc,
  output logic [JW-1:0]   jump_adr,
  output logic            re,
  output logic            de,
  output logic            normal,
  output logic [RW-1:0]   rd_adr,
  output logic [RW-1:0]   rs_adr,
  output logic [RW-1:0]   adrD,
  output logic [IMMW-1:0] immediate,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            stall,
  output logic            illegal,
  output logic [CW-1:0]   decode_count
);

  localparam logic [4:0] OP_NOP   = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4,  OP_XOR  = 5'd5,  OP_NXOR = 5'd6,  OP_CMP1 = 5'd7;
  localparam logic [4:0] OP_MOVE  = 5'd8,  OP_STORE= 5'd9,  OP_LOAD = 5'd10, OP_NOT  = 5'd11;
  localparam logic [4:0] OP_ROR   = 5'd12, OP_ROL  = 5'd13, OP_SAL  = 5'd14, OP_SAR  = 5'd15;
  localparam logic [4:0] OP_CMP2  = 5'd16, OP_ADDI = 5'd17, OP_SUBI = 5'd18, OP_JUMP = 5'd19;

  logic [4:0]      op_in;
  logic [RW-1:0]   fa, fb, fc;
  logic [IMMW-1:0] fimm;
  logic [JW-1:0]   fj;

  assign op_in = instruction[IW-1 -: 5];
  assign fa    = instruction[IW-6 -: RW];
  assign fb    = instruction[IW-6-RW -: RW];
  assign fc    = instruction[IW-6-2*RW -: RW];
  assign fimm  = instruction[IMMW-1:0];
  assign fj    = instruction[IW-6 -: JW];

  logic [4:0]      op_next;
  logic [1:0]      alusrc_next;
  logic [JW-1:0]   jump_adr_next;
  logic            re_next, de_next, normal_next, legal_next, reads_rs_next;
  logic [RW-1:0]   rd_next, rs_next, adrd_next;
  logic [IMMW-1:0] imm_next;

  always_comb begin
    op_next       = op_in;
    alusrc_next   = 2'b00;
    jump_adr_next = '0;
    re_next       = 1'b0;
    de_next       = 1'b0;
    normal_next   = 1'b0;
    rd_next       = RW'(1);
    rs_next       = '0;
    adrd_next     = '0;
    imm_next      = '0;
    legal_next    = 1'b1;
    reads_rs_next = 1'b0;
    case (op_in)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NXOR, OP_CMP1, OP_MOVE: begin
        rs_next = fb; rd_next = fa; re_next = 1'b1; alusrc_next = 2'b01; reads_rs_next = 1'b1;
      end
      OP_STORE: begin
        adrd_next = fa; rs_next = fb; de_next = 1'b1; alusrc_next = 2'b01; reads_rs_next = 1'b1;
      end
      OP_LOAD: begin
        adrd_next = fa; rd_next = fb; re_next = 1'b1; alusrc_next = 2'b10;
      end
      OP_NOT: begin
        rs_next = fb; rd_next = fb; re_next = 1'b1; alusrc_next = 2'b01; reads_rs_next = 1'b1;
      end
      OP_ROR, OP_ROL, OP_SAL, OP_SAR: begin
        rs_next = fb; rd_next = fb; re_next = 1'b1; alusrc_next = 2'b00; reads_rs_next = 1'b1;
      end
      OP_CMP2, OP_ADDI: begin
        rs_next = fb; rd_next = fa; adrd_next = fc; de_next = 1'b1; alusrc_next = 2'b01;
        reads_rs_next = 1'b1;
      end
      OP_SUBI: begin
        imm_next = fimm; rd_next = fa; re_next = 1'b1; alusrc_next = 2'b11;
      end
      OP_JUMP: begin
        jump_adr_next = fj; normal_next = 1'b1;
      end
      OP_NOP: ;
      default: begin
        op_next    = OP_NOP;
        legal_next = 1'b0;
      end
    endcase
  end

  logic squash_reg;
  logic hazard, accept, xfer_out;

  // A presented load's destination is the dependent's source: hold it back one cycle.
  assign hazard   = out_valid & (Op == OP_LOAD) & reads_rs_next & (rs_next == rd_adr);
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign stall    = in_valid & hazard;
  assign accept   = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      Op           <= OP_NOP;
      alusrc       <= 2'b00;
      jump_adr     <= '0;
      re           <= 1'b0;
      de           <= 1'b0;
      normal       <= 1'b0;
      rd_adr       <= RW'(1);
      rs_adr       <= '0;
      adrD         <= '0;
      immediate    <= '0;
      illegal      <= 1'b0;
      decode_count <= '0;
      squash_reg   <= 1'b0;
    end else begin
      if (xfer_out)
        out_valid <= 1'b0;
      if (accept) begin
        // A squashed instruction only clears the flag; outputs and counters keep their value.
        if (squash_reg) begin
          squash_reg <= 1'b0;
        end else begin
          out_valid    <= 1'b1;
          Op           <= op_next;
          alusrc       <= alusrc_next;
          jump_adr     <= jump_adr_next;
          re           <= re_next;
          de           <= de_next;
          normal       <= normal_next;
          rd_adr       <= rd_next;
          rs_adr       <= rs_next;
          adrD         <= adrd_next;
          immediate    <= imm_next;
          decode_count <= decode_count + CW'(1);
          if (!legal_next)
            illegal <= 1'b1;
          squash_reg   <= (FLUSH_ON_JUMP != 0) && (op_in == OP_JUMP);
        end
      end
    end
  end

endmodule
